// File: rtl/flopbank_pkg.sv
// Shared constants and helpers for the flopbank multi-port flop array.
// Address width derivation and collision counter sizing live here.
package flopbank_pkg;

    localparam int COLL_W = 8;
    localparam logic [COLL_W-1:0] COLL_MAX = 8'd255;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A single-entry bank still needs a one-bit address port.
    function automatic int aw_for(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/flopbank_merge.sv
// Per-entry priority merge: folds NWR masked writes into one next value
// and a per-bit write enable, with the highest-numbered port winning.
module flopbank_merge
    import flopbank_pkg::*;
#(
    parameter int NWR   = 3,
    parameter int WIDTH = 1
) (
    input  logic [NWR-1:0]       hit,
    input  logic [NWR*WIDTH-1:0] mask,
    input  logic [NWR*WIDTH-1:0] data,
    output logic [WIDTH-1:0]     nxt,
    output logic [WIDTH-1:0]     bwe
);

    // Ascending loop: later ports overwrite earlier ones bit by bit.
    always_comb begin
        nxt = '0;
        bwe = '0;
        for (int p = 0; p < NWR; p++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (hit[p] && mask[p*WIDTH + b]) begin
                    nxt[b] = data[p*WIDTH + b];
                    bwe[b] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flopbank.sv
// Multi-port prioritised flop array with valid tracking, a registered
// read-old-data port and write-collision monitoring.
module flopbank
    import flopbank_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 4,
    parameter int               NWR       = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = aw_for(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic [NWR*WIDTH-1:0] wr_mask,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic [DEPTH-1:0]     valid_vec,
    output logic                 collide,
    output logic [COLL_W-1:0]    collide_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [NWR-1:0]   hit [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [WIDTH-1:0] bwe [DEPTH];
    logic [DEPTH-1:0] set_valid;
    logic             collide_now;
    logic             rd_in_range;

    // Out-of-range addresses never match any entry, so they cannot write,
    // set valid or contribute to a collision.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = 0; p < NWR; p++) begin
                hit[e][p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(e));
            end
        end
    end

    always_comb begin
        set_valid   = '0;
        collide_now = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int p = 0; p < NWR; p++) begin
                if (hit[e][p] && (|wr_mask[p*WIDTH +: WIDTH])) begin
                    set_valid[e] = 1'b1;
                end
            end
            if ($countones(hit[e]) > 1) begin
                collide_now = 1'b1;
            end
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        flopbank_merge #(
            .NWR   (NWR),
            .WIDTH (WIDTH)
        ) u_merge (
            .hit  (hit[e]),
            .mask (wr_mask),
            .data (wr_data),
            .nxt  (nxt[e]),
            .bwe  (bwe[e])
        );
    end

    assign rd_in_range = (32'(rd_addr) < DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= RESET_VAL;
            end
            valid_vec   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            collide     <= 1'b0;
            collide_cnt <= '0;
        end else begin
            rd_data  <= rd_in_range ? mem[rd_addr] : '0;
            rd_valid <= rd_in_range ? valid_vec[rd_addr] : 1'b0;
            collide  <= collide_now;
            if (collide_now && (collide_cnt != COLL_MAX)) begin
                collide_cnt <= collide_cnt + 1'b1;
            end
            // Clear wins over every write landing in the same cycle.
            if (clr) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem[e] <= RESET_VAL;
                end
                valid_vec <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem[e] <= (mem[e] & ~bwe[e]) | (nxt[e] & bwe[e]);
                end
                valid_vec <= valid_vec | set_valid;
            end
        end
    end

endmodule

// File: tb/tb_flopbank.sv
// Directed bench for flopbank (WIDTH=4, DEPTH=3, NWR=3, RESET_VAL=4'hA)
// with a behavioural array model compared every cycle on the falling edge.
module tb_flopbank;

    localparam int W  = 4;
    localparam int D  = 3;
    localparam int N  = 3;
    localparam int AW = 2;
    localparam logic [W-1:0] RV = 4'hA;

    logic           clk = 1'b0;
    logic           reset;
    logic           clr;
    logic [N-1:0]   wr_en;
    logic [N*AW-1:0] wr_addr;
    logic [N*W-1:0] wr_data;
    logic [N*W-1:0] wr_mask;
    logic [AW-1:0]  rd_addr;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic [D-1:0]   valid_vec;
    logic           collide;
    logic [7:0]     collide_cnt;

    int n_checks = 0;
    int n_errors = 0;

    flopbank #(.WIDTH(W), .DEPTH(D), .NWR(N), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .valid_vec(valid_vec), .collide(collide),
        .collide_cnt(collide_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: array of entries, ports applied in order.
    logic [W-1:0] m_mem [D];
    logic [D-1:0] m_valid;
    logic [W-1:0] m_rd_data;
    logic         m_rd_valid;
    logic         m_collide;
    int           m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < D; e++) m_mem[e] = RV;
            m_valid = '0; m_rd_data = '0; m_rd_valid = 1'b0;
            m_collide = 1'b0; m_cnt = 0;
        end else begin
            int uses [D];
            int a;
            logic [W-1:0] msk;
            if (int'(rd_addr) < D) begin
                m_rd_data = m_mem[rd_addr]; m_rd_valid = m_valid[rd_addr];
            end else begin
                m_rd_data = '0; m_rd_valid = 1'b0;
            end
            for (int e = 0; e < D; e++) uses[e] = 0;
            for (int p = 0; p < N; p++) begin
                a = int'(wr_addr[p*AW +: AW]);
                if (wr_en[p] && a < D) uses[a]++;
            end
            m_collide = 1'b0;
            for (int e = 0; e < D; e++) if (uses[e] >= 2) m_collide = 1'b1;
            if (m_collide && m_cnt < 255) m_cnt++;
            if (clr) begin
                for (int e = 0; e < D; e++) m_mem[e] = RV;
                m_valid = '0;
            end else begin
                for (int p = 0; p < N; p++) begin
                    a   = int'(wr_addr[p*AW +: AW]);
                    msk = wr_mask[p*W +: W];
                    if (wr_en[p] && a < D) begin
                        m_mem[a] = (m_mem[a] & ~msk) | (wr_data[p*W +: W] & msk);
                        if (msk != '0) m_valid[a] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (rd_data !== m_rd_data || rd_valid !== m_rd_valid || valid_vec !== m_valid ||
            collide !== m_collide || collide_cnt !== 8'(m_cnt)) begin
            n_errors++;
            $display("FAIL model_cmp t=%0t: got rd=%h rv=%b vv=%b col=%b cnt=%0d, expected rd=%h rv=%b vv=%b col=%b cnt=%0d",
                     $time, rd_data, rd_valid, valid_vec, collide, collide_cnt,
                     m_rd_data, m_rd_valid, m_valid, m_collide, m_cnt);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        clr = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    endtask

    task automatic set_port(input int p, input int a, input int d, input int m);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*W +: W] = W'(d);
        wr_mask[p*W +: W] = W'(m);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_valid_vec", int'(valid_vec), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_cnt", int'(collide_cnt), 0);

        for (int a = 0; a < D; a++) begin
            rd_addr = AW'(a);
            step();
            check("rst_read_data", int'(rd_data), 'hA);
            check("rst_read_valid", int'(rd_valid), 0);
        end

        // Three ports, one address: port 2 wins, one collision.
        set_port(0, 1, 1, 'hF); set_port(1, 1, 2, 'hF); set_port(2, 1, 3, 'hF);
        step();
        idle();
        check("coll3_collide", int'(collide), 1);
        check("coll3_cnt", int'(collide_cnt), 1);
        check("coll3_valid", int'(valid_vec), 'b010);
        rd_addr = 2'd1;
        step();
        check("coll3_data", int'(rd_data), 3);
        check("coll3_collide_drop", int'(collide), 0);

        // Partial mask from the higher port: F with low two bits cleared.
        set_port(0, 2, 'hF, 'hF); set_port(2, 2, 0, 'h3);
        step();
        idle();
        rd_addr = 2'd2;
        step();
        check("mask_merge", int'(rd_data), 'hC);
        check("mask_cnt", int'(collide_cnt), 2);

        // Read-old-data on a same-cycle write.
        rd_addr = 2'd0;
        set_port(0, 0, 5, 'hF);
        step();
        idle();
        check("rod_old", int'(rd_data), 'hA);
        check("rod_old_valid", int'(rd_valid), 0);
        step();
        check("rod_new", int'(rd_data), 5);
        check("rod_new_valid", int'(rd_valid), 1);

        // Out-of-range address 3 on a 3-entry bank.
        set_port(0, 3, 7, 'hF); set_port(1, 3, 9, 'hF);
        step();
        idle();
        check("oor_collide", int'(collide), 0);
        check("oor_valid", int'(valid_vec), 'b111);
        check("oor_cnt", int'(collide_cnt), 2);
        rd_addr = 2'd3;
        step();
        check("oor_rd_data", int'(rd_data), 0);
        check("oor_rd_valid", int'(rd_valid), 0);
        rd_addr = 2'd0;
        step();
        check("oor_entry0", int'(rd_data), 5);

        // Clear together with a colliding write.
        clr = 1'b1;
        set_port(0, 0, 6, 'hF); set_port(1, 0, 1, 'hF);
        step();
        idle();
        check("clr_valid", int'(valid_vec), 0);
        check("clr_collide", int'(collide), 1);
        check("clr_cnt", int'(collide_cnt), 3);
        step();
        check("clr_data", int'(rd_data), 'hA);
        check("clr_rd_valid", int'(rd_valid), 0);

        // Enabled write with an all-zero mask does not mark the entry.
        set_port(0, 1, 'hF, 0);
        step();
        idle();
        check("zero_mask_valid", int'(valid_vec), 0);

        // Saturation of the collision counter.
        set_port(0, 0, 1, 'hF); set_port(1, 0, 2, 'hF);
        repeat (300) step();
        idle();
        check("sat_cnt", int'(collide_cnt), 255);
        step();
        check("sat_hold", int'(collide_cnt), 255);

        // Reset between edges must act without a clock.
        set_port(2, 1, 4, 'hF);
        step();
        reset = 1'b1;
        #2;
        check("async_rd_data", int'(rd_data), 0);
        check("async_valid", int'(valid_vec), 0);
        check("async_cnt", int'(collide_cnt), 0);
        check("async_collide", int'(collide), 0);
        reset = 1'b0;
        idle();
        set_port(1, 2, 3, 'hF);
        rd_addr = 2'd2;
        step();
        idle();
        check("post_rst_valid", int'(valid_vec), 'b100);
        step();
        check("post_rst_data", int'(rd_data), 3);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flopbank.md
# flopbank

Parametrised multi-port flop array: DEPTH entries of WIDTH bits, written by NWR prioritised write ports per cycle. When several ports hit the same bit, the highest-numbered port wins, matching "last nonblocking assignment wins" flop semantics. Sits beside the flopcode synthesis regression as the general enabled/multi-assignment flop primitive. Also provides per-entry valid tracking, a registered read port and collision monitoring.

## Interface
- WIDTH, 1, bits per entry (≥1)
- DEPTH, 4, number of entries (≥1, need not be a power of 2)
- NWR, 3, number of write ports (≥1)
- RESET_VAL, 0, WIDTH-bit value loaded into every entry on reset and clear
- AW (derived), max(1, clog2(DEPTH)), address width
- clk  input  1  clock; all state updates on posedge
- reset  input  1  reset; asynchronous, active-high
- clr  input  1  synchronous clear of array and valid bits
- wr_en  input  NWR  per-port write enable
- wr_addr  input  NWR*AW  port p address at [p*AW +: AW]
- wr_data  input  NWR*WIDTH  port p data at [p*WIDTH +: WIDTH]
- wr_mask  input  NWR*WIDTH  port p per-bit write mask; 1 = write bit
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  registered valid bit of the read entry
- valid_vec  output  DEPTH  entry e has been written since last reset/clr
- collide  output  1  registered pulse: write collision in previous cycle
- collide_cnt  output  8  saturating collision count

## Operation
- Per entry e, per bit b, on posedge: next = wr_data[p][b] for the highest p with wr_en[p], wr_addr[p]==e and wr_mask[p][b]; otherwise hold.
- An entry's valid bit sets when any enabled in-range port addresses it with a nonzero mask. A valid bit never clears except by reset or clr.
- Addresses ≥ DEPTH: writes are ignored, do not set valid and do not count as collisions. A read returns rd_data=0, rd_valid=0.
- clr: all entries ← RESET_VAL, valid_vec ← 0. clr overrides every write in the same cycle and does not affect rd_data, rd_valid or collide_cnt.
- Read: rd_data/rd_valid capture mem[rd_addr]/valid[rd_addr] as they were before this edge's update (read-old-data). A write to rd_addr in the same cycle appears one cycle later.
- Collision: two or more enabled ports target the same in-range address in one cycle, regardless of mask.
  - collide is 1 the following cycle.
  - collide_cnt increments once per colliding cycle, regardless of how many ports or addresses collide, and saturates at 255.
  - collide and collide_cnt still update during clr.

## Timing
- Reset values: every entry = RESET_VAL; valid_vec = 0; rd_data = 0; rd_valid = 0; collide = 0; collide_cnt = 0.
- Write latency 1: a value written at edge k is visible on valid_vec at k and on rd_data at edge k+1.
- Read latency 1 cycle from rd_addr.
- Reset asserted mid-operation forces all state to reset values immediately, with no clock needed. The first write takes effect at the first posedge after reset deasserts.
- No backpressure, no handshake: every enabled write completes in its cycle.

## Structure
- Shared package/include flopbank_pkg: clog2 function, AW derivation, collide counter width (8) and saturation constant.
- Sub-module flopbank_merge: combinational per-entry priority merge over NWR ports. Inputs are hit vector, masks and data; outputs are next-value and write-bit-enable. It is instantiated DEPTH times.
- Top holds the array, valid bits, read register and collision logic.

## Test plan
- Reset then read all addresses with WIDTH=4, RESET_VAL=4'hA: rd_data=4'hA, rd_valid=0, valid_vec=0, collide_cnt=0.
- Ports 0,1,2 write addr 1 with data 1,2,3, full masks, same cycle: entry 1 = 3, collide=1 next cycle, collide_cnt=1.
- Port 0 writes 4'hF with mask 4'hF and port 2 writes 4'h0 with mask 4'h3, both to addr 2: entry 2 = 4'hC. Port 1 disabled throughout.
- rd_addr=0 while port 0 writes 5 to addr 0: next rd_data = old value; the cycle after, rd_data=5, rd_valid=1.
- DEPTH=3: write addr 3 → no change, valid_vec unchanged, collide 0; read addr 3 → rd_data=0, rd_valid=0.
- Drive 300 colliding cycles: collide_cnt stops at 255.
- Assert clr together with a write: entry = RESET_VAL, valid cleared.
- Assert reset mid-stream, between edges: outputs return to reset values without a clock.
